vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Upstream pixel-timing stage for the 800x600 sprite display. It generates the X/Y scan coordinates consumed by the widget sprite blocks. It emits a single-cycle move-enable pulse once per N frames during vertical blanking, which keeps sprite state machines from advancing mid-frame. It also registers the composited sprite RGB and the syncs so that colour, blanking and syncs reach the VGA pins aligned.

Parameters:
H_VISIBLE, 800, active pixels per line
H_FP, 56, horizontal front porch
H_SYNC, 120, hsync pulse width
H_BP, 64, horizontal back porch
V_VISIBLE, 600, active lines
V_FP, 37, vertical front porch
V_SYNC, 6, vsync pulse width
V_BP, 23, vertical back porch
SYNC_POL, 1, active level of hsync/vsync (1 = positive)
SPEED_DIV, 1, frames per move_en pulse (1..15)

Ports:
clk  in  1  pixel clock (50 MHz for 800x600@72)
reset  in  1  synchronous, active-high
rgb_in  in  12  composited {r,g,b} for the current X,Y (combinational from sprites)
X  out  11  current column, 0..H_TOTAL-1
Y  out  11  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, delayed 1 cycle vs X
vsync  out  1  vertical sync, delayed 1 cycle vs Y
video_on  out  1  active-area flag, delayed 1 cycle
rgb_out  out  12  blanked, registered colour to pins
frame_tick  out  1  one-cycle pulse, start of vertical blank
move_en  out  1  one-cycle pulse, every SPEED_DIV-th frame_tick

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- H_TOTAL = 1040, V_TOTAL = 666 with the default parameters.
- Reset: X=0, Y=0, video_on=0, rgb_out=0, frame_tick=0, move_en=0, divider=0; hsync/vsync = !SYNC_POL.
- Reset mid-frame takes effect on the next edge, with no partial-line completion.
- Counters: X increments every clk. When X==H_TOTAL-1, X wraps to 0 and Y increments. When Y==V_TOTAL-1 and X wraps, Y also wraps to 0. Both are 11-bit unsigned with no intermediate overflow.
- Output stage, latency 1 cycle: registered from the current X,Y:
  - hsync = SYNC_POL when H_VISIBLE+H_FP <= X < H_VISIBLE+H_FP+H_SYNC (856..975); otherwise !SYNC_POL.
  - vsync = SYNC_POL when V_VISIBLE+V_FP <= Y < V_VISIBLE+V_FP+V_SYNC (637..642); otherwise !SYNC_POL.
  - video_on = (X<H_VISIBLE)&&(Y<V_VISIBLE).
  - rgb_out = that same condition ? rgb_in : 12'h000.
- frame_tick: high for exactly the cycle in which X==0 and Y==V_VISIBLE. It is generated from next-count values so that it aligns with X/Y rather than the delayed outputs.
- Divider: a 4-bit counter advances on each frame_tick and wraps at SPEED_DIV-1.
- move_en is high in the same cycle as frame_tick when divider==SPEED_DIV-1; otherwise low. With SPEED_DIV=1, move_en equals frame_tick.
- First frame_tick after reset release: 624000 edges after the reset edge. Subsequent ticks come every 692640 cycles.
- move_en is never high while video_on could become 1 within the same frame. Sprite positions are therefore stable across the visible area.
- SPEED_DIV=0 is illegal; the implementation treats it as 1.

Decomposition:
- Package vga_pkg: COORD_W=11, RGB_W=12, default 800x600@72 timing constants, and the derived H_TOTAL/V_TOTAL.
- Sub-module wrap_counter (parameters WIDTH, MAX; inputs inc, clr; outputs count, at_max). It is instantiated for the horizontal counter, the vertical counter (inc = horizontal at_max) and the frame divider.

Test Plan:
- Reset held 5 cycles, then released → X=0, Y=0, hsync=vsync=0 (SYNC_POL=1), rgb_out=0, move_en=0. X=1 after one edge.
- Run to X=1039, Y=0 → next edge gives X=0, Y=1. At X=1039, Y=665 → next edge gives X=0, Y=0.
- Horizontal sync timing → hsync rises the cycle after X==856 and stays high exactly 120 cycles. vsync is high for 6 full lines beginning the cycle after (X=0, Y=637).
- rgb_in=12'hF0F constant → rgb_out=F0F the cycle after X=799, Y=10; rgb_out=000 the cycle after X=800. rgb_out=000 for every pixel with Y>=600.
- SPEED_DIV=3, run 7 frames → frame_tick at 624000+k·692640. move_en only on the 3rd and 6th ticks, each exactly one cycle wide.
- Assert reset at X=500, Y=300 → the following cycle gives X=0, Y=0, hsync low, divider cleared. The first frame_tick then occurs 624000 edges after the reset edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared widths, types and default 800x600@72 timing for the VGA timing slice.
package vga_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FP      = 56;
  localparam int DEF_H_SYNC    = 120;
  localparam int DEF_H_BP      = 64;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FP      = 37;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BP      = 23;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pin-side VGA bundle: registered syncs, blanking flag and colour.
interface vga_timing_gen_if;

  logic          hsync;
  logic          vsync;
  logic          video_on;
  vga_pkg::rgb_t rgb_out;

  modport master (output hsync, vsync, video_on, rgb_out);
  modport slave  (input  hsync, vsync, video_on, rgb_out);

endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Up-counter that wraps to zero after MAX; clr has priority over inc.
module wrap_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 1
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  assign at_max = (count == LAST);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc)
      count <= at_max ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Scan counters, 1-cycle-registered sync/blank/colour stage and the
// per-N-frames move_en pulse issued at the start of vertical blank.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit SYNC_POL  = 1'b1,
  parameter int SPEED_DIV = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  rgb_t                   rgb_in,
  output coord_t                 X,
  output coord_t                 Y,
  output logic                   frame_tick,
  output logic                   move_en,
  vga_timing_gen_if.master       vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);
  localparam coord_t FT_LINE  = coord_t'(V_VISIBLE - 1);

  // Out-of-range divisors collapse onto the legal 1..15 range (0 behaves as 1).
  localparam int DIV_N = (SPEED_DIV < 1) ? 1 : ((SPEED_DIV > 15) ? 15 : SPEED_DIV);

  logic       h_at_max;
  logic       v_at_max;
  logic       div_at_max;
  logic [3:0] div_count;
  logic       active;
  logic       in_hs;
  logic       in_vs;
  logic       tick_next;
  logic       unused_ok;

  wrap_counter #(.WIDTH(COORD_W), .MAX(H_TOTAL - 1)) u_hcount (
    .clk    (clk),
    .inc    (1'b1),
    .clr    (reset),
    .count  (X),
    .at_max (h_at_max)
  );

  wrap_counter #(.WIDTH(COORD_W), .MAX(V_TOTAL - 1)) u_vcount (
    .clk    (clk),
    .inc    (h_at_max),
    .clr    (reset),
    .count  (Y),
    .at_max (v_at_max)
  );

  wrap_counter #(.WIDTH(4), .MAX(DIV_N - 1)) u_divider (
    .clk    (clk),
    .inc    (frame_tick),
    .clr    (reset),
    .count  (div_count),
    .at_max (div_at_max)
  );

  assign active = (X < H_VIS) && (Y < V_VIS);
  assign in_hs  = (X >= HS_START) && (X < HS_END);
  assign in_vs  = (Y >= VS_START) && (Y < VS_END);

  // Next count will be (0, V_VISIBLE): register now so the pulse lines up with X/Y.
  assign tick_next = h_at_max && (Y == FT_LINE);

  assign unused_ok = ^{v_at_max, div_count};

  always_ff @(posedge clk) begin
    if (reset) begin
      vga.hsync    <= ~SYNC_POL;
      vga.vsync    <= ~SYNC_POL;
      vga.video_on <= 1'b0;
      vga.rgb_out  <= '0;
      frame_tick   <= 1'b0;
      move_en      <= 1'b0;
    end else begin
      vga.hsync    <= in_hs ? SYNC_POL : ~SYNC_POL;
      vga.vsync    <= in_vs ? SYNC_POL : ~SYNC_POL;
      vga.video_on <= active;
      vga.rgb_out  <= active ? rgb_in : '0;
      frame_tick   <= tick_next;
      move_en      <= tick_next && div_at_max;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 800x600 instance for line-level timing, shrunken instance for frame-level.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic   clk = 1'b0;
  logic   reset_a, reset_b;
  rgb_t   rgb_a, rgb_b;
  coord_t xa, ya, xb, yb;
  logic   ft_a, me_a, ft_b, me_b;

  vga_timing_gen_if vga_a ();
  vga_timing_gen_if vga_b ();

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .rgb_in     (rgb_a),
    .X          (xa),
    .Y          (ya),
    .frame_tick (ft_a),
    .move_en    (me_a),
    .vga        (vga_a)
  );

  // Small frame: H_TOTAL=30 (hsync X 20..25), V_TOTAL=20 (vsync Y 15..16), 600 cycles/frame.
  vga_timing_gen #(
    .H_VISIBLE (16), .H_FP (4), .H_SYNC (6), .H_BP (4),
    .V_VISIBLE (12), .V_FP (3), .V_SYNC (2), .V_BP (3),
    .SYNC_POL  (1'b1), .SPEED_DIV (3)
  ) dut_b (
    .clk        (clk),
    .reset      (reset_b),
    .rgb_in     (rgb_b),
    .X          (xb),
    .Y          (yb),
    .frame_tick (ft_b),
    .move_en    (me_b),
    .vga        (vga_b)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    tick_at[$];
  int    move_at[$];
  int    model_bad;
  int    vs_cnt;
  int    vs_first;
  string first_bad;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs dut_b for n cycles from a just-reset (0,0) point against a reference scan model.
  task automatic watch_b(input int n);
    int px, py, ex, ey;
    logic hs, vs, vid, ft;
    rgb_t rgb;
    px = 0; py = 0;
    model_bad = 0; vs_cnt = 0; vs_first = -1; first_bad = "";
    tick_at.delete();
    move_at.delete();
    for (int cyc = 1; cyc <= n; cyc++) begin
      step();
      ex  = (px == 29) ? 0 : px + 1;
      ey  = (px == 29) ? ((py == 19) ? 0 : py + 1) : py;
      hs  = (px >= 20) && (px < 26);
      vs  = (py >= 15) && (py < 17);
      vid = (px < 16) && (py < 12);
      rgb = vid ? rgb_b : 12'h000;
      ft  = (ex == 0) && (ey == 12);
      if (xb !== coord_t'(ex) || yb !== coord_t'(ey) || vga_b.hsync !== hs ||
          vga_b.vsync !== vs || vga_b.video_on !== vid || vga_b.rgb_out !== rgb ||
          ft_b !== ft) begin
        if (model_bad == 0)
          first_bad = $sformatf("cyc %0d got x=%0d y=%0d hs=%b vs=%b vid=%b rgb=%h ft=%b want x=%0d y=%0d hs=%b vs=%b vid=%b rgb=%h ft=%b",
                                cyc, xb, yb, vga_b.hsync, vga_b.vsync, vga_b.video_on, vga_b.rgb_out, ft_b,
                                ex, ey, hs, vs, vid, rgb, ft);
        model_bad++;
      end
      if (cyc <= 600 && vga_b.vsync === 1'b1) begin
        if (vs_first < 0) vs_first = cyc;
        vs_cnt++;
      end
      if (ft_b === 1'b1) tick_at.push_back(cyc);
      if (me_b === 1'b1) move_at.push_back(cyc);
      px = ex; py = ey;
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1;
    rgb_a   = 12'hF0F;
    repeat (5) step();
    n_checks++;
    if ({xa, ya} !== {11'd0, 11'd0}) begin
      n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", xa, ya);
    end
    n_checks++;
    if ({vga_a.hsync, vga_a.vsync, vga_a.video_on} !== 3'b000) begin
      n_fail++; $display("FAIL reset_sync: got hs/vs/vid=%b%b%b, want 000", vga_a.hsync, vga_a.vsync, vga_a.video_on);
    end
    n_checks++;
    if ({vga_a.rgb_out, ft_a, me_a} !== {12'h000, 2'b00}) begin
      n_fail++; $display("FAIL reset_rgb_pulses: got rgb=%h ft=%b me=%b, want 000 0 0", vga_a.rgb_out, ft_a, me_a);
    end
    reset_a = 1'b0;
    step();
    n_checks++;
    if ({xa, ya} !== {11'd1, 11'd0}) begin
      n_fail++; $display("FAIL first_edge_xy: got x=%0d y=%0d, want 1 0", xa, ya);
    end
    n_checks++;
    if ({vga_a.video_on, vga_a.rgb_out} !== {1'b1, 12'hF0F}) begin
      n_fail++; $display("FAIL first_pixel: got vid=%b rgb=%h, want 1 f0f", vga_a.video_on, vga_a.rgb_out);
    end
  endtask

  task automatic test_line_wrap();
    repeat (1038) step();
    n_checks++;
    if ({xa, ya} !== {11'd1039, 11'd0}) begin
      n_fail++; $display("FAIL line_end: got x=%0d y=%0d, want 1039 0", xa, ya);
    end
    step();
    n_checks++;
    if ({xa, ya} !== {11'd0, 11'd1}) begin
      n_fail++; $display("FAIL line_wrap: got x=%0d y=%0d, want 0 1", xa, ya);
    end
  endtask

  task automatic test_hsync();
    int cnt;
    for (int i = 0; i < 2000 && xa !== 11'd856; i++) step();
    n_checks++;
    if ({xa, vga_a.hsync} !== {11'd856, 1'b0}) begin
      n_fail++; $display("FAIL hsync_before: got x=%0d hs=%b, want 856 0", xa, vga_a.hsync);
    end
    step();
    cnt = 0;
    while (vga_a.hsync === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt !== 120) begin
      n_fail++; $display("FAIL hsync_width: got %0d cycles, want 120", cnt);
    end
    n_checks++;
    if (xa !== 11'd977) begin
      n_fail++; $display("FAIL hsync_fall_x: got x=%0d, want 977", xa);
    end
  endtask

  task automatic test_rgb();
    for (int i = 0; i < 20000 && !(xa === 11'd799 && ya === 11'd10); i++) step();
    n_checks++;
    if ({xa, ya, vga_a.rgb_out} !== {11'd799, 11'd10, 12'hF0F}) begin
      n_fail++; $display("FAIL rgb_visible: got x=%0d y=%0d rgb=%h, want 799 10 f0f", xa, ya, vga_a.rgb_out);
    end
    rgb_a = 12'h5A3;
    step();
    n_checks++;
    if ({vga_a.video_on, vga_a.rgb_out} !== {1'b1, 12'h5A3}) begin
      n_fail++; $display("FAIL rgb_last_pixel: got vid=%b rgb=%h, want 1 5a3", vga_a.video_on, vga_a.rgb_out);
    end
    step();
    n_checks++;
    if ({vga_a.video_on, vga_a.rgb_out} !== {1'b0, 12'h000}) begin
      n_fail++; $display("FAIL rgb_blank_x800: got vid=%b rgb=%h, want 0 000", vga_a.video_on, vga_a.rgb_out);
    end
    rgb_a = 12'hF0F;
  endtask

  task automatic test_frame();
    int got;
    int exp_tick[7] = '{360, 960, 1560, 2160, 2760, 3360, 3960};
    rgb_b = 12'hABC;
    reset_b = 1'b1;
    step();
    n_checks++;
    if ({xb, yb, vga_b.hsync, vga_b.vsync, vga_b.video_on, vga_b.rgb_out, ft_b, me_b} !==
        {11'd0, 11'd0, 3'b000, 12'h000, 2'b00}) begin
      n_fail++; $display("FAIL b_reset_state: got x=%0d y=%0d hs=%b vs=%b rgb=%h ft=%b me=%b, want all zero",
                         xb, yb, vga_b.hsync, vga_b.vsync, vga_b.rgb_out, ft_b, me_b);
    end
    reset_b = 1'b0;
    watch_b(4300);
    n_checks++;
    if (model_bad !== 0) begin
      n_fail++; $display("FAIL frame_scan_model: %0d bad cycles, want 0; first %s", model_bad, first_bad);
    end
    n_checks++;
    if ({vs_first, vs_cnt} !== {32'sd451, 32'sd60}) begin
      n_fail++; $display("FAIL vsync_window: got first=%0d width=%0d, want 451 60", vs_first, vs_cnt);
    end
    n_checks++;
    if (tick_at.size() !== 7) begin
      n_fail++; $display("FAIL tick_count: got %0d, want 7", tick_at.size());
    end
    for (int k = 0; k < 7; k++) begin
      got = (k < tick_at.size()) ? tick_at[k] : -1;
      n_checks++;
      if (got !== exp_tick[k]) begin
        n_fail++; $display("FAIL tick_%0d_cycle: got %0d, want %0d", k, got, exp_tick[k]);
      end
    end
    n_checks++;
    if (move_at.size() !== 2) begin
      n_fail++; $display("FAIL move_count: got %0d, want 2", move_at.size());
    end else begin
      n_checks++;
      if ({move_at[0], move_at[1]} !== {32'sd1560, 32'sd3360}) begin
        n_fail++; $display("FAIL move_cycles: got %0d %0d, want 1560 3360", move_at[0], move_at[1]);
      end
    end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 1000 && !(xb === 11'd22 && yb === 11'd6); i++) step();
    n_checks++;
    if ({xb, yb, vga_b.hsync} !== {11'd22, 11'd6, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset_pos: got x=%0d y=%0d hs=%b, want 22 6 1", xb, yb, vga_b.hsync);
    end
    reset_b = 1'b1;
    step();
    n_checks++;
    if ({xb, yb, vga_b.hsync, ft_b, me_b} !== {11'd0, 11'd0, 3'b000}) begin
      n_fail++; $display("FAIL midframe_reset: got x=%0d y=%0d hs=%b ft=%b me=%b, want 0 0 0 0 0",
                         xb, yb, vga_b.hsync, ft_b, me_b);
    end
    reset_b = 1'b0;
    watch_b(1600);
    n_checks++;
    if (model_bad !== 0) begin
      n_fail++; $display("FAIL restart_scan_model: %0d bad cycles, want 0; first %s", model_bad, first_bad);
    end
    n_checks++;
    if (tick_at.size() !== 3 || tick_at[0] !== 360) begin
      n_fail++; $display("FAIL restart_first_tick: got n=%0d first=%0d, want 3 360",
                         tick_at.size(), (tick_at.size() > 0) ? tick_at[0] : -1);
    end
    n_checks++;
    if (move_at.size() !== 1 || move_at[0] !== 1560) begin
      n_fail++; $display("FAIL restart_divider: got n=%0d first=%0d, want 1 1560",
                         move_at.size(), (move_at.size() > 0) ? move_at[0] : -1);
    end
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    rgb_a   = 12'hF0F;
    rgb_b   = 12'hABC;
    test_reset();
    test_line_wrap();
    test_hsync();
    test_rgb();
    test_frame();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
